// File: rtl/dpwm_pkg.sv
// rtl/dpwm_pkg.sv - shared state encoding and default widths for the DPWM duty scheduler
package dpwm_pkg;

  typedef logic [1:0] dpwm_state_t;

  localparam dpwm_state_t ST_IDLE  = 2'd0;
  localparam dpwm_state_t ST_RAMP  = 2'd1;
  localparam dpwm_state_t ST_RUN   = 2'd2;
  localparam dpwm_state_t ST_FAULT = 2'd3;

  localparam int DUTY_W_DEF   = 11;
  localparam int DUTY_LIM_DEF = 1000;
  localparam int STEP_MAX_DEF = 8;

endpackage

// File: rtl/dpwm_slew_step.sv
// rtl/dpwm_slew_step.sv - one-phase slew step: move current toward target by at most STEP_MAX
module dpwm_slew_step
  import dpwm_pkg::*;
#(
  parameter int DUTY_W   = DUTY_W_DEF,
  parameter int STEP_MAX = STEP_MAX_DEF
) (
  input  logic signed [DUTY_W-1:0] cur,
  input  logic signed [DUTY_W-1:0] tgt,
  output logic signed [DUTY_W-1:0] nxt
);

  // Difference is one bit wider so full-scale swings cannot wrap.
  localparam logic signed [DUTY_W:0]   STEP_P_WIDE = (DUTY_W+1)'(STEP_MAX);
  localparam logic signed [DUTY_W:0]   STEP_N_WIDE = -STEP_P_WIDE;
  localparam logic signed [DUTY_W-1:0] STEP_P      = DUTY_W'(STEP_MAX);

  logic signed [DUTY_W:0] diff;

  always_comb begin
    diff = $signed({tgt[DUTY_W-1], tgt}) - $signed({cur[DUTY_W-1], cur});
    if (diff > STEP_P_WIDE) begin
      nxt = cur + STEP_P;
    end else if (diff < STEP_N_WIDE) begin
      nxt = cur - STEP_P;
    end else begin
      nxt = tgt;
    end
  end

endmodule

// File: rtl/dpwm_duty_sched.sv
// rtl/dpwm_duty_sched.sv - three-phase duty scheduler with staged commands, slew limiting and fault handling
module dpwm_duty_sched
  import dpwm_pkg::*;
#(
  parameter int DUTY_W   = DUTY_W_DEF,
  parameter int STEP_MAX = STEP_MAX_DEF,
  parameter int DUTY_LIM = DUTY_LIM_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     fault,
  input  logic                     clr_fault,
  input  logic                     sync,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic signed [DUTY_W-1:0] cmd_duty_a,
  input  logic signed [DUTY_W-1:0] cmd_duty_b,
  input  logic signed [DUTY_W-1:0] cmd_duty_c,
  output logic signed [DUTY_W-1:0] duty_a,
  output logic signed [DUTY_W-1:0] duty_b,
  output logic signed [DUTY_W-1:0] duty_c,
  output logic                     gate_en,
  output logic [1:0]               state
);

  localparam logic signed [DUTY_W-1:0] LIM_P = DUTY_W'(DUTY_LIM);
  localparam logic signed [DUTY_W-1:0] LIM_N = -LIM_P;

  dpwm_state_t state_q, state_d;
  logic        gate_en_q, gate_en_d;
  logic        pending_q, pending_d;

  logic signed [DUTY_W-1:0] duty_q [3];
  logic signed [DUTY_W-1:0] duty_d [3];
  logic signed [DUTY_W-1:0] tgt_q  [3];
  logic signed [DUTY_W-1:0] tgt_d  [3];
  logic signed [DUTY_W-1:0] stg_q  [3];
  logic signed [DUTY_W-1:0] stg_d  [3];
  logic signed [DUTY_W-1:0] cmd_in [3];
  logic signed [DUTY_W-1:0] cmd_clamped [3];
  logic signed [DUTY_W-1:0] eff_tgt  [3];
  logic signed [DUTY_W-1:0] step_nxt [3];

  logic accept;
  logic all_at;

  function automatic logic signed [DUTY_W-1:0] clamp_duty(input logic signed [DUTY_W-1:0] v);
    logic signed [DUTY_W-1:0] r;
    if (v > LIM_P) begin
      r = LIM_P;
    end else if (v < LIM_N) begin
      r = LIM_N;
    end else begin
      r = v;
    end
    return r;
  endfunction

  assign cmd_in[0] = cmd_duty_a;
  assign cmd_in[1] = cmd_duty_b;
  assign cmd_in[2] = cmd_duty_c;

  assign cmd_ready = !pending_q && (state_q != ST_FAULT);
  assign accept    = cmd_valid && cmd_ready;

  // A staged command is promoted on this sync, so the step must aim at it already.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_phase
      assign cmd_clamped[gi] = clamp_duty(cmd_in[gi]);
      assign eff_tgt[gi]     = pending_q ? stg_q[gi] : tgt_q[gi];

      dpwm_slew_step #(
        .DUTY_W   (DUTY_W),
        .STEP_MAX (STEP_MAX)
      ) u_slew (
        .cur (duty_q[gi]),
        .tgt (eff_tgt[gi]),
        .nxt (step_nxt[gi])
      );
    end
  endgenerate

  always_comb begin
    all_at = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (step_nxt[i] != eff_tgt[i]) all_at = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    tgt_d     = tgt_q;
    stg_d     = stg_q;
    pending_d = pending_q;

    if (accept) begin
      stg_d     = cmd_clamped;
      pending_d = 1'b1;
    end

    if (fault) begin
      state_d   = ST_FAULT;
      duty_d    = '{default: '0};
      tgt_d     = '{default: '0};
      stg_d     = '{default: '0};
      pending_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en) state_d = ST_RAMP;
        end
        ST_RAMP, ST_RUN: begin
          if (!en) begin
            state_d   = ST_IDLE;
            duty_d    = '{default: '0};
            tgt_d     = '{default: '0};
            pending_d = 1'b0;
          end else if (sync) begin
            duty_d = step_nxt;
            if (pending_q) begin
              tgt_d     = stg_q;
              pending_d = 1'b0;
            end
            if (state_q == ST_RAMP && all_at) state_d = ST_RUN;
          end
        end
        default: begin
          if (clr_fault) state_d = ST_IDLE;
        end
      endcase
    end

    gate_en_d = (state_d == ST_RAMP) || (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      gate_en_q <= 1'b0;
      pending_q <= 1'b0;
      duty_q    <= '{default: '0};
      tgt_q     <= '{default: '0};
      stg_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      gate_en_q <= gate_en_d;
      pending_q <= pending_d;
      duty_q    <= duty_d;
      tgt_q     <= tgt_d;
      stg_q     <= stg_d;
    end
  end

  assign duty_a  = duty_q[0];
  assign duty_b  = duty_q[1];
  assign duty_c  = duty_q[2];
  assign gate_en = gate_en_q;
  assign state   = state_q;

endmodule

// File: tb/tb_dpwm_duty_sched.sv
// tb/tb_dpwm_duty_sched.sv - directed table-driven bench for dpwm_duty_sched
module tb_dpwm_duty_sched;

  localparam int W = 11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0, fault = 1'b0, clr_fault = 1'b0, sync = 1'b0, cmd_valid = 1'b0;
  logic cmd_ready, gate_en;
  logic [1:0] state;
  logic signed [W-1:0] cmd_duty_a = '0, cmd_duty_b = '0, cmd_duty_c = '0;
  logic signed [W-1:0] duty_a, duty_b, duty_c;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic en, fault, clr, sync, cv;
    int   ca, cb, cc;
    int   rdy_pre;
    int   ea, eb, ec, est, erdy;
  } vec_t;

  typedef struct {
    int ea, eb, est;
  } ramp_t;

  vec_t  tbl[$];
  ramp_t ramp_tab[13];

  always #5 clk = ~clk;

  dpwm_duty_sched #(.DUTY_W(W), .STEP_MAX(8), .DUTY_LIM(1000)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fault      (fault),
    .clr_fault  (clr_fault),
    .sync       (sync),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_duty_a (cmd_duty_a),
    .cmd_duty_b (cmd_duty_b),
    .cmd_duty_c (cmd_duty_c),
    .duty_a     (duty_a),
    .duty_b     (duty_b),
    .duty_c     (duty_c),
    .gate_en    (gate_en),
    .state      (state)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int ea, input int eb, input int ec, input int est);
    chk({tag, "_a"}, int'(duty_a), ea);
    chk({tag, "_b"}, int'(duty_b), eb);
    chk({tag, "_c"}, int'(duty_c), ec);
    chk({tag, "_state"}, int'(state), est);
    chk({tag, "_gate"}, int'(gate_en), (est == 1 || est == 2) ? 1 : 0);
  endtask

  task automatic drive(input logic e, input logic f, input logic c, input logic s, input logic v,
                       input int a, input int b, input int cc);
    en = e; fault = f; clr_fault = c; sync = s; cmd_valid = v;
    cmd_duty_a = W'(a); cmd_duty_b = W'(b); cmd_duty_c = W'(cc);
    @(posedge clk); #1;
    clr_fault = 1'b0; sync = 1'b0; cmd_valid = 1'b0;
  endtask

  function automatic vec_t row(input logic e, input logic f, input logic c, input logic s, input logic v,
                               input int a, input int b, input int cc, input int rp,
                               input int ea, input int eb, input int ec, input int est, input int erdy);
    vec_t r;
    r.en = e; r.fault = f; r.clr = c; r.sync = s; r.cv = v;
    r.ca = a; r.cb = b; r.cc = cc; r.rdy_pre = rp;
    r.ea = ea; r.eb = eb; r.ec = ec; r.est = est; r.erdy = erdy;
    return r;
  endfunction

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      chk($sformatf("row%0d_rdy_pre", i), int'(cmd_ready), tbl[i].rdy_pre);
      drive(tbl[i].en, tbl[i].fault, tbl[i].clr, tbl[i].sync, tbl[i].cv, tbl[i].ca, tbl[i].cb, tbl[i].cc);
      check_out($sformatf("row%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].ec, tbl[i].est);
      chk($sformatf("row%0d_rdy", i), int'(cmd_ready), tbl[i].erdy);
    end
  endtask

  initial begin
    int pa, pb;

    ramp_tab = '{'{8, -8, 1}, '{16, -16, 1}, '{24, -24, 1}, '{32, -32, 1}, '{40, -40, 1},
                 '{48, -48, 1}, '{56, -50, 1}, '{64, -50, 1}, '{72, -50, 1}, '{80, -50, 1},
                 '{88, -50, 1}, '{96, -50, 1}, '{100, -50, 2}};

    //        en f  c  s  v   ca    cb    cc  rp   ea    eb   ec  st rdy
    // 0..6: disable from RUN, re-ramp from 0, clamp and second-command refusal
    tbl.push_back(row(0, 0, 0, 0, 0,    0,     0,   0, 1,    0,    0,  0, 0, 1));
    tbl.push_back(row(1, 0, 0, 0, 0,    0,     0,   0, 1,    0,    0,  0, 1, 1));
    tbl.push_back(row(1, 0, 0, 0, 1,  100,   -50,   0, 1,    0,    0,  0, 1, 0));
    tbl.push_back(row(1, 0, 0, 1, 0,    0,     0,   0, 0,    8,   -8,  0, 1, 1));
    tbl.push_back(row(1, 0, 0, 0, 1, 1023, -1024,   5, 1,    8,   -8,  0, 1, 0));
    tbl.push_back(row(1, 0, 0, 0, 1,  200,   200, 200, 0,    8,   -8,  0, 1, 0));
    tbl.push_back(row(1, 0, 0, 1, 0,    0,     0,   0, 0,   16,  -16,  5, 1, 1));
    // 7..11: command on a sync cycle waits a sync; then setup for fault case
    tbl.push_back(row(1, 0, 0, 1, 1,  990,  -990,  -3, 1, 1000, -1000,  5, 2, 0));
    tbl.push_back(row(1, 0, 0, 1, 0,    0,     0,   0, 0,  992,  -992, -3, 2, 1));
    tbl.push_back(row(0, 0, 0, 0, 0,    0,     0,   0, 1,    0,    0,  0, 0, 1));
    tbl.push_back(row(0, 0, 0, 0, 1,  100,   -50,   0, 1,    0,    0,  0, 0, 0));
    tbl.push_back(row(1, 0, 0, 0, 0,    0,     0,   0, 0,    0,    0,  0, 1, 0));
    // 12..15: fault beats sync, clr_fault ignored while fault held, recovery
    tbl.push_back(row(1, 1, 0, 1, 0,    0,     0,   0, 1,    0,    0,  0, 3, 0));
    tbl.push_back(row(1, 1, 1, 0, 0,    0,     0,   0, 0,    0,    0,  0, 3, 0));
    tbl.push_back(row(0, 0, 1, 0, 0,    0,     0,   0, 0,    0,    0,  0, 0, 1));
    tbl.push_back(row(1, 0, 0, 0, 0,    0,     0,   0, 1,    0,    0,  0, 1, 1));

    // Reset
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 0, 0, 0, 0);
    chk("reset_rdy", int'(cmd_ready), 1);
    rst = 1'b1;

    // Command staged in IDLE, then ramp with a sync every 16 cycles
    drive(0, 0, 0, 0, 1, 100, -50, 0);
    chk("idle_stage_rdy", int'(cmd_ready), 0);
    check_out("idle_stage", 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check_out("enter_ramp", 0, 0, 0, 1);
    pa = 0; pb = 0;
    for (int k = 0; k < 13; k++) begin
      repeat (15) drive(1, 0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("hold%0d_a", k + 1), int'(duty_a), pa);
      chk($sformatf("hold%0d_b", k + 1), int'(duty_b), pb);
      drive(1, 0, 0, 1, 0, 0, 0, 0);
      check_out($sformatf("sync%0d", k + 1), ramp_tab[k].ea, ramp_tab[k].eb, 0, ramp_tab[k].est);
      pa = ramp_tab[k].ea; pb = ramp_tab[k].eb;
    end

    run_rows(0, 6);

    // Ramp the clamped command (16 -> 1000) to completion
    repeat (123) begin
      drive(1, 0, 0, 1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0);
    end
    check_out("clamp_end", 1000, -1000, 5, 2);

    run_rows(7, 11);

    repeat (5) begin
      drive(1, 0, 0, 1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0);
    end
    check_out("pre_fault", 40, -40, 0, 1);

    run_rows(12, 15);

    // Staging was wiped by FAULT: the first sync finds targets at 0 and settles
    drive(1, 0, 0, 1, 0, 0, 0, 0);
    check_out("post_fault_sync", 0, 0, 0, 2);

    // Reset mid-RUN drops a pending command
    drive(1, 0, 0, 0, 1, 50, 50, 50);
    chk("mid_rst_pend", int'(cmd_ready), 0);
    rst = 1'b0;
    drive(1, 0, 0, 1, 0, 0, 0, 0);
    check_out("mid_rst", 0, 0, 0, 0);
    chk("mid_rst_rdy", int'(cmd_ready), 1);
    rst = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0, 0, 0);
    check_out("after_rst_sync", 0, 0, 0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dpwm_duty_sched.md
DPWM_DUTY_SCHED -- requirements
Module: dpwm_duty_sched

Interface
REQ-001 The block SHALL have parameter DUTY_W, default 11, the signed duty width matching the per-phase DPWM duty input.
REQ-002 The block SHALL have parameter STEP_MAX, default 8, the maximum duty change per phase per carrier period.
REQ-003 The block SHALL have parameter DUTY_LIM, default 1000, the absolute duty clamp (positive, less than 2^(DUTY_W-1)).
REQ-004 clk  input  1  the single system clock; all logic is on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-low.
REQ-006 en  input  1  level; requests converter run.
REQ-007 fault  input  1  level; hardware fault indication.
REQ-008 clr_fault  input  1  pulse; requests exit from FAULT.
REQ-009 sync  input  1  single-cycle pulse marking the carrier-period boundary.
REQ-010 cmd_valid / cmd_ready  input / output  1 / 1  command handshake.
REQ-011 cmd_duty_a, cmd_duty_b, cmd_duty_c  input  DUTY_W  signed per-phase duty commands.
REQ-012 duty_a, duty_b, duty_c  output  DUTY_W  signed duty values driven to the three phase DPWM wrappers.
REQ-013 gate_en  output  1  gate-drive enable.
REQ-014 state  output  2  current state: IDLE=0, RAMP=1, RUN=2, FAULT=3.

Function
REQ-015 A command SHALL be accepted on a cycle with cmd_valid=1 and cmd_ready=1. Each phase value is clamped to the range [-DUTY_LIM, +DUTY_LIM], stored in a staging register, and the pending flag is set.
REQ-016 cmd_ready SHALL equal (not pending) AND (state != FAULT), so the block holds at most one staged command.
REQ-017 On a sync in RAMP or RUN with pending=1, the staged values SHALL be copied into the targets and pending cleared; the step on that same sync uses the new targets.
REQ-018 On each sync in RAMP or RUN, each output SHALL move toward its target by min(|target-duty|, STEP_MAX). The difference is computed at DUTY_W+1 bits, and a phase already at its target does not move.
REQ-019 Outputs SHALL update on the clock edge at which sync is sampled; they are registered, with one-cycle latency from sync to the output change, and remain constant between syncs.
REQ-020 A command accepted on the same cycle as a sync SHALL NOT affect that sync's step; it is applied at the next sync.
REQ-021 A command accepted in IDLE SHALL load the staging register only; targets update at the first sync after entering RAMP.
REQ-022 State transitions, one per clock:
 - IDLE->RAMP when en=1 and fault=0.
 - RAMP->RUN at a sync after which all three outputs equal their targets.
 - RUN stays in RUN; slew limiting still applies to new targets.
 - RAMP or RUN -> IDLE when en=0.
 - Any state -> FAULT when fault=1.
 - FAULT->IDLE when clr_fault=1 and fault=0.
REQ-023 Fault SHALL have priority over en, sync and clr_fault.
REQ-024 On entering IDLE or FAULT, the outputs, targets and pending flag SHALL be cleared on the next edge; the staging register is cleared in FAULT only.
REQ-025 gate_en SHALL be 1 exactly in RAMP and RUN, and registered together with state.
REQ-026 Outputs SHALL start from 0 on every IDLE->RAMP transition.

Reset
REQ-027 With rst=0 at a clock edge, the block SHALL take these values on that edge: state=IDLE, duty_a/b/c=0, targets=0, staging=0, pending=0, gate_en=0. cmd_ready is therefore 1 after reset.
REQ-028 Reset asserted mid-RAMP or mid-RUN SHALL override all other inputs and discard any pending command.

Structure
REQ-029 The state encoding, DUTY_W default and default DUTY_LIM SHALL reside in the shared package dpwm_pkg.
REQ-030 The per-phase clamp-free slew step (current, target, STEP_MAX -> next) SHALL be one sub-module, dpwm_slew_step, instantiated three times.

Verification
REQ-031 Reset: hold rst=0 for 2 cycles -> duty 0/0/0, gate_en=0, state=0, cmd_ready=1.
REQ-032 Ramp: en=1, cmd (100,-50,0), sync every 16 cycles.
 - After the first sync, duties are (8,-8,0).
 - Phase B reaches -50 at sync 7.
 - At sync 13, duties are (100,-50,0) and state=RUN.
REQ-033 Clamp and handshake:
 - cmd_duty_a=1023 -> target 1000.
 - A second cmd_valid before the next sync sees cmd_ready=0.
 - A cmd presented on the sync cycle is applied only at the following sync.
REQ-034 Fault: assert fault during RAMP at duty 40 -> next edge duties 0, gate_en=0, state=3.
 - clr_fault with fault=1 -> remains in FAULT.
 - clr_fault with fault=0 -> IDLE.
REQ-035 Disable: drop en in RUN at duty 100 -> next edge state=IDLE, duties 0. Re-asserting en ramps from 0.
